// File: rtl/shake256_absorb_ctrl.sv
// SHAKE256 absorb controller: serial bits -> 64-bit lanes, pad10*1 + 1111 suffix.
// Define SHAKE_LEN_CNT_EN to build the accepted-message-bit counter on msg_bits.
module shake256_absorb_ctrl #(
   parameter int RATE_LANES = 17,
   parameter int LEN_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             in_ready,
   output logic             lane_we,
   output logic [4:0]       lane_idx,
   output logic [63:0]      lane_data,
   output logic             perm_start,
   input  logic             perm_done,
   output logic             absorb_done,
   output logic [LEN_W-1:0] msg_bits
);

   localparam int POS_W = $clog2(RATE_LANES * 64);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(RATE_LANES * 64 - 1);

   typedef enum logic [2:0] {ABSORB, PAD, FLUSH, PERM_WAIT, DONE} state_t;

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   logic [POS_W-1:0] bit_pos_q, bit_pos_d;
   logic [2:0]       k_q, k_d;
   logic [63:0]      sr_q, sr_d;
   logic             in_ready_q, in_ready_d;
   logic             lane_we_q, lane_we_d;
   logic [4:0]       lane_idx_q, lane_idx_d;
   logic [63:0]      lane_data_q, lane_data_d;
   logic             perm_start_q, perm_start_d;
   logic             absorb_done_q, absorb_done_d;
   logic             accept, at_last, wr_en, wr_bit;

   assign accept  = in_valid && in_ready_q && (state_q == ABSORB);
   assign at_last = (bit_pos_q == LAST_POS);

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      bit_pos_d     = bit_pos_q;
      k_d           = k_q;
      sr_d          = sr_q;
      lane_we_d     = 1'b0;
      lane_idx_d    = lane_idx_q;
      lane_data_d   = lane_data_q;
      perm_start_d  = 1'b0;
      absorb_done_d = 1'b0;
      wr_en         = 1'b0;
      wr_bit        = 1'b0;
      unique case (state_q)
         ABSORB: begin
            if (accept) begin
               wr_en  = 1'b1;
               wr_bit = in_bit;
               if (in_last) k_d = 3'd0;
               if (at_last) begin
                  state_d = FLUSH;
                  ret_d   = in_last ? PAD : ABSORB;
               end else if (in_last) begin
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            // four suffix ones plus the leading pad one, then zeros to the final one
            wr_en  = 1'b1;
            wr_bit = (k_q < 3'd5) || at_last;
            k_d    = (k_q < 3'd5) ? k_q + 3'd1 : k_q;
            if (at_last) begin
               state_d = FLUSH;
               ret_d   = (k_q < 3'd5) ? PAD : DONE;
            end
         end
         FLUSH: begin
            perm_start_d = 1'b1;
            state_d      = PERM_WAIT;
         end
         PERM_WAIT: begin
            if (perm_done) begin
               bit_pos_d     = '0;
               state_d       = ret_q;
               absorb_done_d = (ret_q == DONE);
            end
         end
         DONE: begin
            state_d   = ABSORB;
            bit_pos_d = '0;
         end
         default: state_d = ABSORB;
      endcase
      if (wr_en) begin
         sr_d[bit_pos_q[5:0]] = wr_bit;
         bit_pos_d = bit_pos_q + 1'b1;
         if (&bit_pos_q[5:0]) begin
            lane_we_d   = 1'b1;
            lane_idx_d  = 5'(bit_pos_q >> 6);
            lane_data_d = sr_d;
            sr_d        = '0;
         end
      end
      in_ready_d = (state_d == ABSORB);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ABSORB;
         ret_q         <= ABSORB;
         bit_pos_q     <= '0;
         k_q           <= '0;
         sr_q          <= '0;
         in_ready_q    <= 1'b0;
         lane_we_q     <= 1'b0;
         lane_idx_q    <= '0;
         lane_data_q   <= '0;
         perm_start_q  <= 1'b0;
         absorb_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         bit_pos_q     <= bit_pos_d;
         k_q           <= k_d;
         sr_q          <= sr_d;
         in_ready_q    <= in_ready_d;
         lane_we_q     <= lane_we_d;
         lane_idx_q    <= lane_idx_d;
         lane_data_q   <= lane_data_d;
         perm_start_q  <= perm_start_d;
         absorb_done_q <= absorb_done_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign lane_we     = lane_we_q;
   assign lane_idx    = lane_idx_q;
   assign lane_data   = lane_data_q;
   assign perm_start  = perm_start_q;
   assign absorb_done = absorb_done_q;

`ifdef SHAKE_LEN_CNT_EN
   logic [LEN_W-1:0] msg_bits_q, msg_bits_d;

   always_comb begin
      msg_bits_d = msg_bits_q;
      if (accept) msg_bits_d = msg_bits_q + 1'b1;
      if (state_q == DONE) msg_bits_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) msg_bits_q <= '0;
      else        msg_bits_q <= msg_bits_d;
   end

   assign msg_bits = msg_bits_q;
`else
   assign msg_bits = '0;
`endif

endmodule

// File: tb/tb_shake256_absorb_ctrl.sv
// Directed bench for shake256_absorb_ctrl: lane images, spill, gaps, reset abandon.
// Expected lane words are hand-derived pad10*1 images with the 1111 suffix.
module tb_shake256_absorb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        lane_we;
   logic [4:0]  lane_idx;
   logic [63:0] lane_data;
   logic        perm_start;
   logic        perm_done;
   logic        absorb_done;
   logic [31:0] msg_bits;
   logic        core_done = 1'b0;
   logic        stray_done = 1'b0;
   logic        auto_perm = 1'b1;

   assign perm_done = core_done | stray_done;

   shake256_absorb_ctrl #(.RATE_LANES(17), .LEN_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
      .in_last(in_last), .in_ready(in_ready), .lane_we(lane_we),
      .lane_idx(lane_idx), .lane_data(lane_data), .perm_start(perm_start),
      .perm_done(perm_done), .absorb_done(absorb_done), .msg_bits(msg_bits)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  idx;
      logic [63:0] data;
   } lane_t;

   lane_t lane_log[$];
   lane_t ref_a[$];
   lane_t ref_d[$];
   int    strobe_cnt = 0;
   int    perm_cnt = 0;
   int    done_cnt = 0;
   int    overlap_err = 0;
   int    busy_err = 0;
   bit    busy = 1'b0;
   int    n_chk = 0;
   int    n_fail = 0;

   always @(negedge clk) begin
      int s;
      s = int'(lane_we) + int'(perm_start) + int'(absorb_done);
      strobe_cnt <= strobe_cnt + s;
      if (s > 1) overlap_err <= overlap_err + 1;
      if (perm_start) perm_cnt <= perm_cnt + 1;
      if (absorb_done) done_cnt <= done_cnt + 1;
      if (lane_we) lane_log.push_back({lane_idx, lane_data});
      if (busy && in_ready) busy_err <= busy_err + 1;
      if (!rst_n || perm_done) busy <= 1'b0;
      else if (lane_we && lane_idx == 5'd16) busy <= 1'b1;
   end

   always @(negedge clk) begin
      if (perm_start && auto_perm) begin
         repeat (3) @(posedge clk);
         #1 core_done = 1'b1;
         @(posedge clk);
         #1 core_done = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit msg_bit(input int mode, input int i);
      if (mode == 0) return 1'b0;
      return ((i * 37 + i / 3) % 7) < 3;
   endfunction

   task automatic send_msg(input int n, input int mode, input bit gaps);
      bit ok;
      int to;
      for (int i = 0; i < n; i++) begin
         while (gaps && ($urandom % 2 == 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_bit   = msg_bit(mode, i);
         in_last  = (i == n - 1);
         to = 0;
         do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            to++;
         end while (!ok && to < 5000);
         if (!ok) begin
            check("accept_to", 64'(ok), 64'd1);
            i = n;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int to = 0;
      while (done_cnt == d0 && to < 20000) begin
         @(posedge clk);
         #1;
         to++;
      end
      check("done_to", 64'(done_cnt != d0), 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag, input int b, input int lo,
                             input int hi);
      logic [63:0] acc = '0;
      for (int i = lo; i <= hi; i++)
         if (b + i < lane_log.size()) acc |= lane_log[b + i].data;
      check(tag, acc, 64'd0);
   endtask

   task automatic check_idx(input string tag, input int b, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (b + i >= lane_log.size() || lane_log[b + i].idx != 5'(i % 17))
            bad++;
      check(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      int b, p0, d0, s0, bad;
      logic [31:0] exp_bits;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_strobes", 64'({lane_we, perm_start, absorb_done}), 64'd0);
      check("rst_lane", {lane_data[58:0], lane_idx}, 64'd0);
      check("rst_msg_bits", 64'(msg_bits), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", 64'(in_ready), 64'd1);

      // 1-bit '0' message
      b = lane_log.size(); p0 = perm_cnt; d0 = done_cnt;
      send_msg(1, 0, 1'b0);
      wait_done(d0);
      check("a_nlanes", 64'(lane_log.size() - b), 64'd17);
      check_idx("a_idx", b, 17);
      check("a_lane0", lane_log[b].data, 64'h0000_0000_0000_003E);
      check_zero("a_lane1_15", b, 1, 15);
      check("a_lane16", lane_log[b + 16].data, 64'h8000_0000_0000_0000);
      check("a_perms", 64'(perm_cnt - p0), 64'd1);
      check("a_dones", 64'(done_cnt - d0), 64'd1);
      check("a_msg_clr", 64'(msg_bits), 64'd0);
      for (int i = 0; i < 17; i++) ref_a.push_back(lane_log[b + i]);

      // 1082 zero bits: padding just fits
      b = lane_log.size(); p0 = perm_cnt; d0 = done_cnt;
      send_msg(1082, 0, 1'b0);
      wait_done(d0);
      check("b_nlanes", 64'(lane_log.size() - b), 64'd17);
      check_zero("b_lane0_15", b, 0, 15);
      check("b_lane16", lane_log[b + 16].data, 64'hFC00_0000_0000_0000);
      check("b_perms", 64'(perm_cnt - p0), 64'd1);

      // 1083 zero bits: padding spills into a second block
      b = lane_log.size(); p0 = perm_cnt; d0 = done_cnt;
      send_msg(1083, 0, 1'b0);
      wait_done(d0);
      check("c_nlanes", 64'(lane_log.size() - b), 64'd34);
      check_idx("c_idx", b, 34);
      check_zero("c_lane0_15", b, 0, 15);
      check("c_lane16", lane_log[b + 16].data, 64'hF800_0000_0000_0000);
      check_zero("c_blk2_0_15", b, 17, 32);
      check("c_blk2_16", lane_log[b + 33].data, 64'h8000_0000_0000_0000);
      check("c_perms", 64'(perm_cnt - p0), 64'd2);
      check("c_dones", 64'(done_cnt - d0), 64'd1);

      // 2000-bit pattern, gap-free then with random in_valid gaps
`ifdef SHAKE_LEN_CNT_EN
      exp_bits = 32'd2000;
`else
      exp_bits = 32'd0;
`endif
      b = lane_log.size(); d0 = done_cnt;
      send_msg(2000, 1, 1'b0);
      check("d_msg_bits", 64'(msg_bits), 64'(exp_bits));
      wait_done(d0);
      for (int i = b; i < lane_log.size(); i++) ref_d.push_back(lane_log[i]);
      check("d_nlanes", 64'(ref_d.size()), 64'd34);
      b = lane_log.size(); d0 = done_cnt; s0 = busy_err;
      send_msg(2000, 1, 1'b1);
      check("d_gap_msg_bits", 64'(msg_bits), 64'(exp_bits));
      wait_done(d0);
      check("d_gap_nlanes", 64'(lane_log.size() - b), 64'(ref_d.size()));
      bad = 0;
      for (int i = 0; i < ref_d.size(); i++)
         if (b + i >= lane_log.size() || lane_log[b + i] !== ref_d[i]) bad++;
      check("d_gap_lanes", 64'(bad), 64'd0);
      check("d_ready_busy", 64'(busy_err - s0), 64'd0);

      // reset while waiting on the permutation, then a stray perm_done
      auto_perm = 1'b0;
      p0 = perm_cnt; bad = 0;
      send_msg(1, 0, 1'b0);
      while (perm_cnt == p0 && bad < 3000) begin
         @(posedge clk);
         #1;
         bad++;
      end
      check("e_perm_seen", 64'(perm_cnt - p0), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      s0 = strobe_cnt;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      stray_done = 1'b1;
      @(posedge clk);
      #1;
      stray_done = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("e_no_strobes", 64'(strobe_cnt - s0), 64'd0);
      auto_perm = 1'b1;
      b = lane_log.size(); d0 = done_cnt;
      send_msg(1, 0, 1'b0);
      wait_done(d0);
      bad = 0;
      for (int i = 0; i < 17; i++)
         if (b + i >= lane_log.size() || lane_log[b + i] !== ref_a[i]) bad++;
      check("e_relanes", 64'(bad), 64'd0);

      // stray perm_done and in_last without in_valid while idle in ABSORB
      s0 = strobe_cnt;
      stray_done = 1'b1;
      in_last = 1'b1;
      @(posedge clk);
      #1;
      stray_done = 1'b0;
      in_last = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("f_no_strobes", 64'(strobe_cnt - s0), 64'd0);
      check("f_ready", 64'(in_ready), 64'd1);
      b = lane_log.size(); d0 = done_cnt;
      send_msg(1, 0, 1'b0);
      wait_done(d0);
      check("f_lane0", lane_log[b].data, 64'h0000_0000_0000_003E);
      check("f_lane16", lane_log[b + 16].data, 64'h8000_0000_0000_0000);
      check("overlap", 64'(overlap_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
